mult_sequencer: RTL and testbench

Controller for the iterative multiplier and HI/LO register pair in the 5-stage pipeline. It accepts a MULTU sitting in EX and sequences the shift-add datapath with load and step strobes for MULT_CYCLES cycles. It then issues a single HI/LO write strobe. While busy, it stalls the pipeline whenever a dependent instruction appears: mfhi/mflo in ID, or a second multiply in EX.

---
 rtl/mips_mult_pkg.sv | 16 +
 rtl/mult_step_counter.sv | 32 +++
 rtl/mult_sequencer.sv | 98 +++++++++
 tb/tb_mult_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mult_pkg.sv
// Shared constants and state encoding for the multiply/divide sequencing logic.
package mips_mult_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    WB   = 2'b10
  } mult_state_t;

endpackage

// File: rtl/mult_step_counter.sv
// Iteration counter with clear, increment and terminal count at MAX_COUNT-1.
`default_nettype none
module mult_step_counter #(
  parameter int MAX_COUNT = 32,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // Clear has priority so a terminal-count wrap and a fresh load both land on zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == CNT_W'(MAX_COUNT - 1));

endmodule
`default_nettype wire

// File: rtl/mult_sequencer.sv
// Iterative-multiplier controller: load, MULT_CYCLES steps, HI/LO write, pipeline interlock.
// Optional signed MULT support is enabled by defining MULT_SIGNED_EN.
`default_nettype none
module mult_sequencer
  import mips_mult_pkg::*;
#(
  parameter int MULT_CYCLES = 32,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [5:0]       ex_opcode,
  input  logic [5:0]       ex_funct,
  input  logic             id_mfhilo,
  input  logic             flush,
  output logic             mul_load,
  output logic             mul_step,
  output logic             hilo_we,
  output logic             stall_pipe,
  output logic             busy,
`ifdef MULT_SIGNED_EN
  output logic             mul_signed,
`endif
  output logic [CNT_W-1:0] step_cnt
);

  mult_state_t      r_state;
  logic             w_is_mult;
  logic             w_load;
  logic             w_run;
  logic             w_tc;
  logic [CNT_W-1:0] w_cnt;

`ifdef MULT_SIGNED_EN
  logic r_signed;
  assign w_is_mult = ex_valid & (ex_opcode == OP_RTYPE) &
                     ((ex_funct == FUNCT_MULTU) | (ex_funct == FUNCT_MULT));
`else
  assign w_is_mult = ex_valid & (ex_opcode == OP_RTYPE) & (ex_funct == FUNCT_MULTU);
`endif

  // Gated by rst so the strobe stays low while reset is held with a multiply in EX.
  assign w_load = (r_state == IDLE) & w_is_mult & ~flush & rst;
  assign w_run  = (r_state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
`ifdef MULT_SIGNED_EN
      r_signed <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) r_state <= RUN;
`ifdef MULT_SIGNED_EN
          r_signed <= w_load & (ex_funct == FUNCT_MULT);
`endif
        end
        RUN: begin
          if (w_tc) r_state <= WB;
        end
        WB: begin
          r_state  <= IDLE;
`ifdef MULT_SIGNED_EN
          r_signed <= 1'b0;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  mult_step_counter #(
    .MAX_COUNT (MULT_CYCLES),
    .CNT_W     (CNT_W)
  ) u_step_counter (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_load | (w_run & w_tc)),
    .i_inc (w_run),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  assign mul_load   = w_load;
  assign mul_step   = w_run;
  assign hilo_we    = (r_state == WB);
  assign busy       = (r_state != IDLE);
  assign stall_pipe = busy & (id_mfhilo | w_is_mult);
  assign step_cnt   = w_cnt;
`ifdef MULT_SIGNED_EN
  assign mul_signed = r_signed;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a cycle-stamped hilo_we scoreboard.
`default_nettype none
module tb_mult_sequencer;

  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_MULT  = 6'h18;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_valid;
  logic [5:0] ex_opcode;
  logic [5:0] ex_funct;
  logic       id_mfhilo;
  logic       flush;
  logic       mul_load, mul_step, hilo_we, stall_pipe, busy;
  logic [5:0] step_cnt;
`ifdef MULT_SIGNED_EN
  logic       mul_signed;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_q[$];

  mult_sequencer #(.MULT_CYCLES(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_opcode  (ex_opcode),
    .ex_funct   (ex_funct),
    .id_mfhilo  (id_mfhilo),
    .flush      (flush),
    .mul_load   (mul_load),
    .mul_step   (mul_step),
    .hilo_we    (hilo_we),
    .stall_pipe (stall_pipe),
    .busy       (busy),
`ifdef MULT_SIGNED_EN
    .mul_signed (mul_signed),
`endif
    .step_cnt   (step_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_valid  = 1'b0;
    ex_opcode = 6'h00;
    ex_funct  = 6'h00;
    id_mfhilo = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic set_mult(input logic [5:0] f);
    ex_valid  = 1'b1;
    ex_opcode = 6'h00;
    ex_funct  = f;
  endtask

  // Scoreboard: each accepted multiply expects hilo_we exactly 33 cycles after its load.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("strobe_excl", 32'($countones({mul_load, mul_step, hilo_we}) <= 1), 32'd1);
      if (hilo_we === 1'b1) begin
        if (exp_q.size() == 0) chk("hilo_unexpected_qsize", 32'(exp_q.size()), 32'd1);
        else chk("hilo_cycle", 32'(cyc), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b0;
    set_mult(F_MULTU);
    id_mfhilo = 1'b1;
    flush     = 1'b0;
    #1;
    chk("rst_load", 32'(mul_load), 32'd0);
    chk("rst_stall", 32'(stall_pipe), 32'd0);
    repeat (3) begin
      step();
      ex_valid  = 1'($urandom);
      ex_opcode = 6'($urandom_range(0, 1));
      ex_funct  = 6'($urandom_range(6'h18, 6'h19));
      id_mfhilo = 1'($urandom);
      flush     = 1'($urandom);
      #1;
      chk("rst_outs", 32'({mul_load, mul_step, hilo_we, stall_pipe, busy}), 32'd0);
      chk("rst_cnt", 32'(step_cnt), 32'd0);
    end
    idle_in();
    step();
    rst = 1'b1;
    #1;
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Single multiply
    step();
    set_mult(F_MULTU);
    #1;
    chk("single_load", 32'(mul_load), 32'd1);
    chk("single_nostall", 32'(stall_pipe), 32'd0);
    exp_q.push_back(cyc + 33);
    step();
    idle_in();
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("run_step", 32'(mul_step), 32'd1);
      chk("run_cnt", 32'(step_cnt), 32'(i));
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_nohilo", 32'(hilo_we), 32'd0);
      step();
    end
    #1;
    chk("wb_hilo", 32'(hilo_we), 32'd1);
    chk("wb_nostep", 32'(mul_step), 32'd0);
    chk("wb_cnt", 32'(step_cnt), 32'd0);
    step();
    #1;
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_hilo", 32'(hilo_we), 32'd0);

    // mflo interlock
    step();
    set_mult(F_MULTU);
    #1;
    exp_q.push_back(cyc + 33);
    step();
    idle_in();
    id_mfhilo = 1'b1;
    for (int i = 0; i < 33; i++) begin
      #1;
      chk("mf_stall", 32'(stall_pipe), 32'd1);
      step();
    end
    #1;
    chk("mf_release", 32'(stall_pipe), 32'd0);
    chk("mf_idle", 32'(busy), 32'd0);
    id_mfhilo = 1'b0;

    // Second multiply held in EX
    step();
    set_mult(F_MULTU);
    #1;
    exp_q.push_back(cyc + 33);
    step();
    for (int i = 0; i < 33; i++) begin
      #1;
      chk("hold_stall", 32'(stall_pipe), 32'd1);
      chk("hold_noload", 32'(mul_load), 32'd0);
      step();
    end
    #1;
    chk("second_load", 32'(mul_load), 32'd1);
    chk("second_nostall", 32'(stall_pipe), 32'd0);
    exp_q.push_back(cyc + 33);
    step();
    idle_in();
    repeat (33) step();
    #1;
    chk("second_done", 32'(busy), 32'd0);

    // Flushed multiply, then flush raised mid-run
    step();
    set_mult(F_MULTU);
    flush = 1'b1;
    #1;
    chk("flush_noload", 32'(mul_load), 32'd0);
    step();
    #1;
    chk("flush_idle", 32'(busy), 32'd0);
    flush = 1'b0;
    #1;
    chk("unflush_load", 32'(mul_load), 32'd1);
    exp_q.push_back(cyc + 33);
    step();
    idle_in();
    repeat (5) step();
    flush = 1'b1;
    repeat (28) step();
    flush = 1'b0;
    #1;
    chk("flush_done", 32'(busy), 32'd0);

    // Signed MULT funct
    step();
    set_mult(F_MULT);
    #1;
`ifdef MULT_SIGNED_EN
    chk("mult_load", 32'(mul_load), 32'd1);
    exp_q.push_back(cyc + 33);
    step();
    idle_in();
    #1;
    chk("mult_signed", 32'(mul_signed), 32'd1);
    repeat (33) step();
    #1;
    chk("mult_signed_clr", 32'(mul_signed), 32'd0);
`else
    chk("mult_noload", 32'(mul_load), 32'd0);
    step();
    idle_in();
    #1;
`endif
    chk("mult_busy", 32'(busy), 32'd0);

    // Mid-operation reset
    step();
    set_mult(F_MULTU);
    #1;
    exp_q.push_back(cyc + 33);
    step();
    set_mult(F_MULT);
    #1;
`ifdef MULT_SIGNED_EN
    chk("mult_stall", 32'(stall_pipe), 32'd1);
`else
    chk("mult_nostall", 32'(stall_pipe), 32'd0);
`endif
    idle_in();
    repeat (10) step();
    #1;
    chk("pre_rst_cnt", 32'(step_cnt), 32'd10);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cnt", 32'(step_cnt), 32'd0);
    chk("midrst_step", 32'(mul_step), 32'd0);
    exp_q.delete();
    step();
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      chk("midrst_nohilo", 32'(hilo_we), 32'd0);
      step();
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
